// File: rtl/hazard_fwd_ctrl_pkg.sv
// Shared constants and slot types for the 5-stage pipeline hazard/forwarding controller.
package hazard_fwd_ctrl_pkg;

   localparam int REG_AW = 5;
   localparam int TW     = 2;

   localparam logic [TW-1:0] TUSE_NONE = 2'd3;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_M  = 2'b01,
      FWD_W  = 2'b10,
      FWD_E  = 2'b11
   } fwd_sel_e;

   typedef struct packed {
      logic [REG_AW-1:0] dst;
      logic [TW-1:0]     tnew;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
   } e_slot_t;

   typedef struct packed {
      logic [REG_AW-1:0] dst;
      logic [TW-1:0]     tnew;
      logic [REG_AW-1:0] rt;
   } m_slot_t;

   function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] t);
      return (t == '0) ? '0 : t - 1'b1;
   endfunction

endpackage

// File: rtl/hazard_fwd_ctrl_src_sel.sv
// Per-operand priority matcher: youngest in-flight writer wins, a not-yet-ready
// younger writer blocks older sources and requests a stall.
module hzd_src_sel
   import hazard_fwd_ctrl_pkg::*;
(
   input  logic [REG_AW-1:0] src,
   input  logic [TW-1:0]     tuse,
   input  logic [REG_AW-1:0] e_dst,
   input  logic [TW-1:0]     e_tnew,
   input  logic [REG_AW-1:0] m_dst,
   input  logic [TW-1:0]     m_tnew,
   input  logic [REG_AW-1:0] w_dst,
   output logic              stall_req,
   output logic [1:0]        sel
);

   logic hit_e, hit_m, hit_w;

   always_comb begin
      hit_e = (src != '0) && (src == e_dst);
      hit_m = (src != '0) && (src == m_dst);
      hit_w = (src != '0) && (src == w_dst);
   end

   // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      stall_req = 1'b0;
      sel       = FWD_RF;
      if (tuse != TUSE_NONE)
         stall_req = (hit_e && (e_tnew > tuse)) || (hit_m && (m_tnew > tuse));
      if (hit_e) begin
         if (e_tnew == '0) sel = FWD_E;
      end else if (hit_m) begin
         if (m_tnew == '0) sel = FWD_M;
      end else if (hit_w) begin
         sel = FWD_W;
      end
   end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller: holds E/M/W writer slots, drives forward selects and D stall.
// Optional feature macro: HZD_MDU_BUSY_EN (multiply/divide unit busy stall).
module hazard_fwd_ctrl
   import hazard_fwd_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              flush,
   input  logic [REG_AW-1:0] d_rs,
   input  logic [REG_AW-1:0] d_rt,
   input  logic [TW-1:0]     d_tuse_rs,
   input  logic [TW-1:0]     d_tuse_rt,
   input  logic [REG_AW-1:0] d_dst,
   input  logic [TW-1:0]     d_tnew,
`ifdef HZD_MDU_BUSY_EN
   input  logic              d_uses_md,
   input  logic              e_md_start,
   input  logic              md_busy,
`endif
   output logic              stall,
   output logic [1:0]        fwd_rs_d,
   output logic [1:0]        fwd_rt_d,
   output logic [1:0]        fwd_rs_e,
   output logic [1:0]        fwd_rt_e,
   output logic              fwd_rt_m
);

   e_slot_t           e_q;
   m_slot_t           m_q;
   logic [REG_AW-1:0] w_dst_q;

   logic       stall_rs, stall_rt;
   logic [1:0] e_stall_unused;

   hzd_src_sel u_d_rs (
      .src(d_rs), .tuse(d_tuse_rs),
      .e_dst(e_q.dst), .e_tnew(e_q.tnew),
      .m_dst(m_q.dst), .m_tnew(m_q.tnew), .w_dst(w_dst_q),
      .stall_req(stall_rs), .sel(fwd_rs_d)
   );

   hzd_src_sel u_d_rt (
      .src(d_rt), .tuse(d_tuse_rt),
      .e_dst(e_q.dst), .e_tnew(e_q.tnew),
      .m_dst(m_q.dst), .m_tnew(m_q.tnew), .w_dst(w_dst_q),
      .stall_req(stall_rt), .sel(fwd_rt_d)
   );

   // E-stage operands only look at older writers, so the E source is tied off.
   hzd_src_sel u_e_rs (
      .src(e_q.rs), .tuse(TUSE_NONE),
      .e_dst('0), .e_tnew('0),
      .m_dst(m_q.dst), .m_tnew(m_q.tnew), .w_dst(w_dst_q),
      .stall_req(e_stall_unused[0]), .sel(fwd_rs_e)
   );

   hzd_src_sel u_e_rt (
      .src(e_q.rt), .tuse(TUSE_NONE),
      .e_dst('0), .e_tnew('0),
      .m_dst(m_q.dst), .m_tnew(m_q.tnew), .w_dst(w_dst_q),
      .stall_req(e_stall_unused[1]), .sel(fwd_rt_e)
   );

   always_comb begin
      stall = stall_rs | stall_rt;
`ifdef HZD_MDU_BUSY_EN
      stall = stall | (d_uses_md & (md_busy | e_md_start));
`endif
   end

   assign fwd_rt_m = (m_q.rt != '0) && (m_q.rt == w_dst_q);

   // NOTE: sequential state uses non-blocking assignments so every slot shifts on the same edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         e_q     <= '0;
         m_q     <= '0;
         w_dst_q <= '0;
      end else if (flush) begin
         e_q     <= '0;
         m_q     <= '0;
         w_dst_q <= '0;
      end else begin
         w_dst_q <= m_q.dst;
         m_q     <= '{dst: e_q.dst, tnew: dec_sat(e_q.tnew), rt: e_q.rt};
         if (stall)
            e_q <= '0;
         else
            e_q <= '{dst: d_dst, tnew: d_tnew, rs: d_rs, rt: d_rt};
      end
   end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl; also covers the HZD_MDU_BUSY_EN stall when defined.
module tb_hazard_fwd_ctrl;

   logic       clk;
   logic       reset_n;
   logic       flush;
   logic [4:0] d_rs, d_rt, d_dst;
   logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
`ifdef HZD_MDU_BUSY_EN
   logic       d_uses_md, e_md_start, md_busy;
`endif
   logic       stall;
   logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
   logic       fwd_rt_m;

   int errors = 0;
   int checks = 0;

   hazard_fwd_ctrl dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
      .d_dst(d_dst), .d_tnew(d_tnew),
`ifdef HZD_MDU_BUSY_EN
      .d_uses_md(d_uses_md), .e_md_start(e_md_start), .md_busy(md_busy),
`endif
      .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
      .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic st,
                             input logic [1:0] rsd, input logic [1:0] rtd,
                             input logic [1:0] rse, input logic [1:0] rte,
                             input logic rtm);
      check($sformatf("%s.stall", tag), {1'b0, stall}, {1'b0, st});
      check($sformatf("%s.rs_d", tag), fwd_rs_d, rsd);
      check($sformatf("%s.rt_d", tag), fwd_rt_d, rtd);
      check($sformatf("%s.rs_e", tag), fwd_rs_e, rse);
      check($sformatf("%s.rt_e", tag), fwd_rt_e, rte);
      check($sformatf("%s.rt_m", tag), {1'b0, fwd_rt_m}, {1'b0, rtm});
   endtask

   task automatic drive(input logic [4:0] rs, input logic [1:0] tu_rs,
                        input logic [4:0] rt, input logic [1:0] tu_rt,
                        input logic [4:0] dst, input logic [1:0] tnew);
      d_rs = rs; d_tuse_rs = tu_rs;
      d_rt = rt; d_tuse_rt = tu_rt;
      d_dst = dst; d_tnew = tnew;
      #1;
   endtask

   task automatic nop();
      drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      nop();
      repeat (3) tick();
   endtask

   initial begin
      reset_n = 1'b0;
      flush   = 1'b0;
`ifdef HZD_MDU_BUSY_EN
      d_uses_md = 1'b0; e_md_start = 1'b0; md_busy = 1'b0;
`endif
      nop();
      #12;
      expect_out("reset", 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();

      // 1. reset mid-stream with lw $5 in M
      drive(5'd29, 2'd1, 5'd0, 2'd3, 5'd5, 2'd2);
      tick();
      nop();
      tick();
      drive(5'd5, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0);
      expect_out("t1_pre", 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
      reset_n = 1'b0;
      #1;
      expect_out("t1_rst", 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
      #1;
      reset_n = 1'b1;
      #1;
      expect_out("t1_rel", 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
      drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd9, 2'd1);
      tick();
      drive(5'd9, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0);
      expect_out("t1_refill", 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
      drain();

      // 2. addu $3 ; beq $3,$4
      drive(5'd1, 2'd1, 5'd2, 2'd1, 5'd3, 2'd1);
      tick();
      drive(5'd3, 2'd0, 5'd4, 2'd0, 5'd0, 2'd0);
      expect_out("t2_stall", 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
      tick();
      expect_out("t2_fwd", 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
      tick();
      nop();
      expect_out("t2_e", 1'b0, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0);
      drain();

      // 3. lw $5 ; addu $6,$5,$1
      drive(5'd29, 2'd1, 5'd0, 2'd3, 5'd5, 2'd2);
      tick();
      drive(5'd5, 2'd1, 5'd1, 2'd1, 5'd6, 2'd1);
      expect_out("t3_stall", 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
      tick();
      expect_out("t3_go", 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
      drive(5'd6, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0);
      expect_out("t3_bubble", 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
      drive(5'd5, 2'd1, 5'd1, 2'd1, 5'd6, 2'd1);
      tick();
      nop();
      expect_out("t3_e", 1'b0, 2'b00, 2'b00, 2'b10, 2'b00, 1'b0);
      drain();

      // 4. jal ; jr $31
      drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd31, 2'd0);
      tick();
      drive(5'd31, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0);
      expect_out("t4_jr", 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
      drain();

      // 5. writes to $0 while D reads $0
      drive(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd2);
      for (int i = 0; i < 4; i++) begin
         expect_out($sformatf("t5_%0d", i), 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
         tick();
      end
      drain();

      // 6. addu $7 ; sw $7
      drive(5'd1, 2'd1, 5'd2, 2'd1, 5'd7, 2'd1);
      tick();
      drive(5'd29, 2'd1, 5'd7, 2'd2, 5'd0, 2'd0);
      expect_out("t6_d", 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
      tick();
      nop();
      expect_out("t6_e", 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0);
      tick();
      expect_out("t6_m", 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
      tick();
      expect_out("t6_after", 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
      drain();

      // flush wins over stall and clears the slots
      drive(5'd29, 2'd1, 5'd0, 2'd3, 5'd8, 2'd2);
      tick();
      drive(5'd8, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0);
      expect_out("fl_pre", 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      expect_out("fl_post", 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
      drain();

`ifdef HZD_MDU_BUSY_EN
      d_uses_md = 1'b1;
      md_busy   = 1'b1;
      #1;
      expect_out("md_busy0", 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
      tick();
      expect_out("md_busy1", 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
      md_busy = 1'b0;
      #1;
      expect_out("md_free", 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
      e_md_start = 1'b1;
      #1;
      expect_out("md_start", 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
      e_md_start = 1'b0;
      d_uses_md  = 1'b0;
      #1;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
